// File: rtl/clock_div.sv
// clock_div: divides i_clk down to a single-cycle, i_clk-synchronous enable
// strobe o_clk that fires once every DIV = I_CLK_FRQ / FREQUENCY cycles.
// o_clk is a clock enable for i_clk logic, never a clock in its own right.

module clock_div #(
  parameter int unsigned I_CLK_FRQ = 100_000_000,
  parameter int unsigned FREQUENCY = 1_000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_clk
);

  // Floor division; the zero guard only keeps elaboration arithmetic sane,
  // the illegal-parameter check below reports the real problem.
  localparam int unsigned DIV_RAW = (FREQUENCY == 32'd0) ? 32'd1 : (I_CLK_FRQ / FREQUENCY);
  // A request at or above the input rate degenerates to "always enabled".
  localparam int unsigned DIV     = (DIV_RAW < 32'd1) ? 32'd1 : DIV_RAW;
  // Counter width max(1, clog2(DIV)): DIV of 1 or 2 still needs one bit.
  localparam int unsigned CW      = (DIV <= 32'd2) ? 32'd1 : $clog2(DIV);

  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 32'd1);
  localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

  // Reject zero rates at elaboration instead of building a meaningless divider.
  generate
    if ((I_CLK_FRQ == 32'd0) || (FREQUENCY == 32'd0)) begin : g_bad_param
      $error("clock_div: I_CLK_FRQ and FREQUENCY must both be non-zero");
    end
  endgenerate

  // Power-up values cover FPGA targets that never see i_rst asserted.
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic          clk_q = 1'b0;
  logic          clk_d;

  // Next-state: count 0..DIV-1, wrap to 0 and raise the strobe on the terminal count.
  always_comb begin
    cnt_d = '0;
    clk_d = 1'b0;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      clk_d = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
      clk_d = 1'b0;
    end
  end

  // State register; synchronous reset restarts the phase and kills any pulse in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= clk_d;
    end
  end

  // Strobe comes straight from a flop, so no input reaches o_clk combinationally.
  assign o_clk = clk_q;

endmodule

// File: tb/tb_clock_div.sv
// Self-checking bench for clock_div: four instances (DIV = 10, 1, 1, 3) share
// one clock and reset. The driver pushes the expected strobe levels into a
// scoreboard queue; a monitor pops and compares after every rising edge.

module tb_clock_div;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic o10, o1a, o1b, o3;

  always #5 clk = ~clk;

  clock_div #(.I_CLK_FRQ(100), .FREQUENCY(10))  u_d10 (.i_clk(clk), .i_rst(rst), .o_clk(o10));
  clock_div #(.I_CLK_FRQ(100), .FREQUENCY(100)) u_d1a (.i_clk(clk), .i_rst(rst), .o_clk(o1a));
  clock_div #(.I_CLK_FRQ(100), .FREQUENCY(250)) u_d1b (.i_clk(clk), .i_rst(rst), .o_clk(o1b));
  clock_div #(.I_CLK_FRQ(100), .FREQUENCY(30))  u_d3  (.i_clk(clk), .i_rst(rst), .o_clk(o3));

  typedef struct {
    bit e10;
    bit e1a;
    bit e1b;
    bit e3;
    bit win;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int k     = 0;   // non-reset edges since the last reset edge
  int win_pulses10 = 0;
  int win_pulses3  = 0;

  function automatic void check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endfunction

  // Reference: after the k-th non-reset edge the strobe is high iff k is a multiple of DIV.
  function automatic bit model(input bit r, input int edges, input int div);
    return (!r) && (edges > 0) && ((edges % div) == 0);
  endfunction

  task automatic step(input bit r, input bit w);
    exp_t e;
    @(negedge clk);
    rst = r;
    if (r) k = 0;
    else   k = k + 1;
    e.e10 = model(r, k, 10);
    e.e1a = model(r, k, 1);
    e.e1b = model(r, k, 1);
    e.e3  = model(r, k, 3);
    e.win = w;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input bit r, input bit w);
    for (int i = 0; i < n; i++) step(r, w);
  endtask

  // Monitor: after each rising edge, compare outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("o_clk_div10",  int'(o10), int'(e.e10));
      check("o_clk_div1a",  int'(o1a), int'(e.e1a));
      check("o_clk_div1b",  int'(o1b), int'(e.e1b));
      check("o_clk_div3",   int'(o3),  int'(e.e3));
      if (e.win && o10) win_pulses10++;
      if (e.win && o3)  win_pulses3++;
    end
  end

  initial begin
    // 1: three reset cycles, outputs held low
    run(3, 1'b1, 1'b0);
    // 2: 1000 free-running cycles -> 100 pulses at DIV=10, 333 at DIV=3
    run(1000, 1'b0, 1'b1);
    // 3: reset for one cycle when the DIV=10 counter sits at 6
    run(2, 1'b1, 1'b0);
    run(6, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(25, 1'b0, 1'b0);
    // 4: reset on the edge following the one that raised the strobe
    run(1, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0);
    run(1, 1'b1, 1'b0);
    run(25, 1'b0, 1'b0);
    // random run lengths and reset bursts
    for (int j = 0; j < 20; j++) begin
      run(int'($urandom_range(1, 40)), 1'b0, 1'b0);
      run(int'($urandom_range(1, 3)), 1'b1, 1'b0);
    end
    run(30, 1'b0, 1'b0);

    // let the monitor drain the last expectation
    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    check("pulses_in_1000_div10", win_pulses10, 100);
    check("pulses_in_1000_div3",  win_pulses3,  333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
